// File: rtl/rng_detect_if.sv
// Valid/ready stream interface carrying a W-bit data word.
interface dti #(
  parameter int unsigned W = 8
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input ready);
  modport consumer (input valid, input data, output ready);
  modport master   (output valid, output data, input ready);
  modport slave    (input valid, input data, output ready);
endinterface

// File: rtl/rng_detect.sv
// Range detector: turns an eot-terminated integer stream into {err, incr, cnt, base}.
// Optional macro RNG_DETECT_ERR_DROP_EN discards results that carry err.
module rng_detect #(
  parameter int unsigned W_DATA    = 16,
  parameter int unsigned W_INCR    = 16,
  parameter int unsigned W_CNT     = 16,
  parameter int unsigned W_START   = 16,
  parameter int unsigned CNT_STEPS = 0,
  parameter int unsigned SIGNED    = 0
) (
  input  logic   clk,
  input  logic   rst,
  dti.consumer   din,
  dti.producer   dout
);

  localparam int unsigned W_D1 = W_DATA + 1;
  localparam int unsigned W_M0 = (W_D1 > W_INCR) ? W_D1 : W_INCR;
  localparam int unsigned W_M1 = ((W_CNT + 1) > W_START) ? (W_CNT + 1) : W_START;
  localparam int unsigned W_X  = ((W_M0 > W_M1) ? W_M0 : W_M1) + 1;
  localparam logic [W_CNT:0] N_MAX = {1'b0, {W_CNT{1'b1}}};
`ifdef RNG_DETECT_ERR_DROP_EN
  localparam bit DROP_ERR = 1'b1;
`else
  localparam bit DROP_ERR = 1'b0;
`endif

  typedef enum logic [1:0] {FIRST, SECOND, RUN, OUT} state_t;

  state_t              state, state_nx;
  logic [W_DATA-1:0]   prev, prev_nx;
  logic [W_START-1:0]  base, base_nx;
  logic [W_D1-1:0]     incr, incr_nx;
  logic [W_CNT:0]      n, n_nx;
  logic                err, err_nx;
  logic                ready, valid;

  logic [W_DATA-1:0]   value;
  logic                eot;
  logic                xfer;
  logic [W_D1-1:0]     diff;
  logic [W_CNT:0]      n_inc;
  logic                n_ovf;
  logic                last_bad;

  // Element extended to W_DATA+1 bits; the MSB is then a true sign bit.
  function automatic logic [W_D1-1:0] ext_d(input logic [W_DATA-1:0] v);
    if (SIGNED != 0) return W_D1'($signed(v));
    return W_D1'(v);
  endfunction

  function automatic logic [W_X-1:0] wide(input logic [W_D1-1:0] v);
    return W_X'($signed(v));
  endfunction

  // Round-trip sizing checks: a value fits if resizing it loses nothing.
  function automatic logic fits_incr(input logic [W_X-1:0] x);
    logic [W_INCR-1:0] s;
    s = W_INCR'(x);
    if (SIGNED != 0) return W_X'($signed(s)) == x;
    return W_X'(s) == x;
  endfunction

  function automatic logic fits_cnt(input logic [W_X-1:0] x);
    logic [W_CNT-1:0] s;
    s = W_CNT'(x);
    if (SIGNED != 0) return W_X'($signed(s)) == x;
    return W_X'(s) == x;
  endfunction

  function automatic logic fits_start(input logic [W_X-1:0] x);
    logic [W_START-1:0] s;
    s = W_START'(x);
    if (SIGNED != 0) return W_X'($signed(s)) == x;
    return W_X'(s) == x;
  endfunction

  assign value    = din.data[W_DATA-1:0];
  assign eot      = din.data[W_DATA];
  assign xfer     = din.valid & ready;
  assign diff     = ext_d(value) - ext_d(prev);
  assign n_ovf    = (n >= N_MAX);
  assign n_inc    = n_ovf ? n : n + (W_CNT + 1)'(1);
  assign last_bad = (CNT_STEPS == 0) && !fits_cnt(wide(ext_d(value)));

  always_comb begin
    state_nx = state;
    prev_nx  = prev;
    base_nx  = base;
    incr_nx  = incr;
    n_nx     = n;
    err_nx   = err;
    if (xfer) prev_nx = value;
    case (state)
      FIRST: if (xfer) begin
        base_nx = W_START'(wide(ext_d(value)));
        n_nx    = (W_CNT + 1)'(1);
        if (!fits_start(wide(ext_d(value)))) err_nx = 1'b1;
        if (eot) begin
          state_nx = OUT;
          if (last_bad) err_nx = 1'b1;
        end else begin
          state_nx = SECOND;
        end
      end
      SECOND: if (xfer) begin
        incr_nx = diff;
        n_nx    = n_inc;
        if (!fits_incr(wide(diff)) || (n_ovf && CNT_STEPS != 0)) err_nx = 1'b1;
        if (eot) begin
          state_nx = OUT;
          if (last_bad) err_nx = 1'b1;
        end else begin
          state_nx = RUN;
        end
      end
      RUN: if (xfer) begin
        n_nx = n_inc;
        if ((diff != incr) || (n_ovf && CNT_STEPS != 0)) err_nx = 1'b1;
        if (eot) begin
          state_nx = OUT;
          if (last_bad) err_nx = 1'b1;
        end
      end
      OUT: if ((DROP_ERR && err) || (valid && dout.ready)) begin
        state_nx = FIRST;
        incr_nx  = '0;
        n_nx     = '0;
        err_nx   = 1'b0;
      end
      default: state_nx = FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FIRST;
      prev  <= '0;
      base  <= '0;
      incr  <= '0;
      n     <= '0;
      err   <= 1'b0;
      ready <= 1'b0;
      valid <= 1'b0;
    end else begin
      state <= state_nx;
      prev  <= prev_nx;
      base  <= base_nx;
      incr  <= incr_nx;
      n     <= n_nx;
      err   <= err_nx;
      ready <= (state_nx != OUT);
      valid <= (state_nx == OUT) && !(DROP_ERR && err_nx);
    end
  end

  logic [W_INCR-1:0] incr_o;
  logic [W_CNT-1:0]  cnt_o;
  logic              err_o;

  always_comb begin
    incr_o = W_INCR'(wide(incr));
    cnt_o  = (CNT_STEPS != 0) ? W_CNT'(n) : W_CNT'(wide(ext_d(prev)));
    err_o  = DROP_ERR ? 1'b0 : err;
  end

  assign din.ready  = ready;
  assign dout.valid = valid;
  assign dout.data  = {err_o, incr_o, cnt_o, base};

endmodule

// File: tb/tb_rng_detect.sv
// Bench for rng_detect: unsigned/inclusive-end and signed/step-count instances fed the same stream.
module tb_rng_detect;

`ifdef RNG_DETECT_ERR_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  typedef logic [15:0] vq_t[$];
  typedef struct {
    int          n;
    logic [15:0] v[8];
    int          bp;
    logic [48:0] ea;
    logic [48:0] eb;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dvalid = 1'b0;
  logic [16:0] ddata = '0;
  logic        dready = 1'b1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dti #(.W(17)) din_a ();
  dti #(.W(17)) din_b ();
  dti #(.W(49)) dout_a ();
  dti #(.W(49)) dout_b ();

  assign din_a.valid  = dvalid;
  assign din_a.data   = ddata;
  assign din_b.valid  = dvalid;
  assign din_b.data   = ddata;
  assign dout_a.ready = dready;
  assign dout_b.ready = dready;

  rng_detect #(.W_DATA(16), .W_INCR(16), .W_CNT(16), .W_START(16), .CNT_STEPS(0), .SIGNED(0))
    u_a (.clk(clk), .rst(rst), .din(din_a), .dout(dout_a));
  rng_detect #(.W_DATA(16), .W_INCR(16), .W_CNT(16), .W_START(16), .CNT_STEPS(1), .SIGNED(1))
    u_b (.clk(clk), .rst(rst), .din(din_b), .dout(dout_b));

  function automatic logic [48:0] pk(input bit e, input logic [15:0] i, input logic [15:0] c,
                                     input logic [15:0] b);
    return {e, i, c, b};
  endfunction

  // Reference: the range is read off the sequence with integer arithmetic.
  function automatic logic [48:0] model(input vq_t v, input bit sgn, input bit steps);
    longint x[$];
    longint incr, cnt;
    bit     e;
    foreach (v[i]) x.push_back(sgn ? longint'($signed(v[i])) : longint'(v[i]));
    e    = 1'b0;
    incr = (x.size() > 1) ? x[1] - x[0] : 0;
    if (sgn) begin
      if (incr < -32768 || incr > 32767) e = 1'b1;
    end else if (incr < 0 || incr > 65535) begin
      e = 1'b1;
    end
    for (int i = 2; i < x.size(); i++)
      if (x[i] - x[i-1] != incr) e = 1'b1;
    cnt = steps ? longint'(x.size()) : x[x.size()-1];
    if (steps && x.size() > 65535) e = 1'b1;
    return {e, 16'(incr), 16'(cnt), 16'(x[0])};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // phase 0: first result cycle, 1: held under backpressure, 2: after release
  task automatic dut_chk(input string tag, input int phase, input bit deliver, input logic v,
                         input logic r, input logic [48:0] d, input logic [48:0] e);
    case (phase)
      0: begin
        chk({tag, ".valid"}, 64'(v), 64'(deliver));
        if (deliver) chk({tag, ".data"}, 64'(d), 64'(e));
        chk({tag, ".in_ready_out"}, 64'(r), 64'(0));
      end
      1: begin
        if (deliver) begin
          chk({tag, ".hold_valid"}, 64'(v), 64'(1));
          chk({tag, ".hold_data"}, 64'(d), 64'(e));
          chk({tag, ".hold_in_ready"}, 64'(r), 64'(0));
        end else begin
          chk({tag, ".drop_valid"}, 64'(v), 64'(0));
        end
      end
      default: begin
        chk({tag, ".rel_valid"}, 64'(v), 64'(0));
        chk({tag, ".rel_in_ready"}, 64'(r), 64'(1));
      end
    endcase
  endtask

  task automatic drive(input vq_t v, input bit eot_last, input int gap_max);
    int w;
    for (int i = 0; i < v.size(); i++) begin
      dvalid = 1'b0;
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      w = 0;
      while (!(din_a.ready && din_b.ready)) begin
        if (w >= 40) begin
          checks++;
          errors++;
          $display("FAIL ready_timeout: din.ready a=%b b=%b after %0d cycles", din_a.ready,
                   din_b.ready, w);
          $display("CHECKS %0d ERRORS %0d", checks, errors);
          $fatal(1, "input never became ready");
        end
        @(negedge clk);
        w++;
      end
      dvalid = 1'b1;
      ddata  = {eot_last && (i == v.size() - 1), v[i]};
      @(posedge clk);
      @(negedge clk);
      dvalid = 1'b0;
    end
  endtask

  task automatic result(input logic [48:0] ea, input logic [48:0] eb, input int bp);
    bit da, db;
    da = !(DROP && ea[48]);
    db = !(DROP && eb[48]);
    dut_chk("a", 0, da, dout_a.valid, din_a.ready, dout_a.data, ea);
    dut_chk("b", 0, db, dout_b.valid, din_b.ready, dout_b.data, eb);
    for (int c = 0; c < bp; c++) begin
      @(negedge clk);
      dut_chk("a", 1, da, dout_a.valid, din_a.ready, dout_a.data, ea);
      dut_chk("b", 1, db, dout_b.valid, din_b.ready, dout_b.data, eb);
    end
    dready = 1'b1;
    @(negedge clk);
    dut_chk("a", 2, da, dout_a.valid, din_a.ready, dout_a.data, ea);
    dut_chk("b", 2, db, dout_b.valid, din_b.ready, dout_b.data, eb);
  endtask

  task automatic run_seq(input vq_t v, input logic [48:0] ea, input logic [48:0] eb,
                         input int bp, input int gap_max);
    dready = (bp == 0);
    drive(v, 1'b1, gap_max);
    result(ea, eb, bp);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    dvalid = 1'b0;
    @(negedge clk);
    chk("rst.a_valid", 64'(dout_a.valid), 64'(0));
    chk("rst.a_ready", 64'(din_a.ready), 64'(0));
    chk("rst.b_valid", 64'(dout_b.valid), 64'(0));
    chk("rst.b_ready", 64'(din_b.ready), 64'(0));
    rst    = 1'b0;
    dready = 1'b1;
    @(negedge clk);
    chk("post_rst.a_ready", 64'(din_a.ready), 64'(1));
    chk("post_rst.b_ready", 64'(din_b.ready), 64'(1));
    chk("post_rst.a_valid", 64'(dout_a.valid), 64'(0));
    chk("post_rst.a_data", 64'(dout_a.data), 64'(0));
    chk("post_rst.b_data", 64'(dout_b.data), 64'(0));
  endtask

  vec_t tbl[8];

  initial begin
    vq_t         q;
    logic [15:0] base, step;
    int          n;

    tbl[0] = '{4, '{16'd3, 16'd5, 16'd7, 16'd9, 16'd0, 16'd0, 16'd0, 16'd0}, 0,
               pk(0, 16'd2, 16'd9, 16'd3), pk(0, 16'd2, 16'd4, 16'd3)};
    tbl[1] = '{1, '{16'd42, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 0,
               pk(0, 16'd0, 16'd42, 16'd42), pk(0, 16'd0, 16'd1, 16'd42)};
    tbl[2] = '{2, '{16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 2,
               pk(0, 16'd1, 16'd1, 16'd0), pk(0, 16'd1, 16'd2, 16'd0)};
    tbl[3] = '{4, '{16'd10, 16'd20, 16'd31, 16'd40, 16'd0, 16'd0, 16'd0, 16'd0}, 0,
               pk(1, 16'd10, 16'd40, 16'd10), pk(1, 16'd10, 16'd4, 16'd10)};
    tbl[4] = '{2, '{16'd1, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 0,
               pk(0, 16'd1, 16'd2, 16'd1), pk(0, 16'd1, 16'd2, 16'd1)};
    tbl[5] = '{4, '{16'd5, 16'd2, 16'hFFFF, 16'hFFFC, 16'd0, 16'd0, 16'd0, 16'd0}, 5,
               pk(1, 16'hFFFD, 16'hFFFC, 16'd5), pk(0, 16'hFFFD, 16'd4, 16'd5)};
    tbl[6] = '{3, '{16'hFFFE, 16'hFFFF, 16'h0000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 1,
               pk(1, 16'd1, 16'd0, 16'hFFFE), pk(0, 16'd1, 16'd3, 16'hFFFE)};
    tbl[7] = '{2, '{16'h7FFF, 16'h8000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 3,
               pk(0, 16'd1, 16'h8000, 16'h7FFF), pk(1, 16'd1, 16'd2, 16'h7FFF)};

    repeat (2) @(negedge clk);
    do_reset();

    foreach (tbl[i]) begin
      q = {};
      for (int j = 0; j < tbl[i].n; j++) q.push_back(tbl[i].v[j]);
      run_seq(q, tbl[i].ea, tbl[i].eb, tbl[i].bp, i % 2);
    end

    // Reset after two elements: the partial sequence must vanish.
    q = '{16'd1, 16'd2};
    drive(q, 1'b0, 0);
    do_reset();
    q = '{16'd7, 16'd8};
    run_seq(q, pk(0, 16'd1, 16'd8, 16'd7), pk(0, 16'd1, 16'd2, 16'd7), 0, 0);

    // Reset while a result is pending.
    dready = 1'b0;
    q = '{16'd3, 16'd5};
    drive(q, 1'b1, 0);
    chk("pending.a_valid", 64'(dout_a.valid), 64'(1));
    do_reset();

    repeat (60) begin
      n    = int'($urandom_range(1, 8));
      base = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       step = 16'(int'($urandom_range(0, 40)) - 20);
        1:       step = 16'($urandom);
        2:       begin base = 16'hFFF8; step = 16'd3; end
        default: begin base = 16'h7FF8; step = 16'd5; end
      endcase
      q = {};
      for (int i = 0; i < n; i++) q.push_back(16'(base + 16'(i) * step));
      if (n > 1 && $urandom_range(0, 3) == 0)
        q[$urandom_range(1, n - 1)] ^= 16'(1 << $urandom_range(0, 15));
      run_seq(q, model(q, 1'b0, 1'b0), model(q, 1'b1, 1'b1), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rng_detect.md
Name: rng_detect

Overview:
- Inverse of the range generator. Consumes an eot-terminated stream of integers and reconstructs the range descriptor {incr, cnt, base} that would regenerate it.
- Flags sequences that are not arithmetic progressions.
- Sits downstream of data producers to compress ramps into a single cfg word for a range generator on the far side of a link.

Parameters:
- W_DATA, 16, width of one input element (excluding eot).
- W_INCR, 16, width of output incr field.
- W_CNT, 16, width of output cnt field.
- W_START, 16, width of output base field.
- CNT_STEPS, 0, 0: cnt = last element value (inclusive end); 1: cnt = number of elements.
- SIGNED, 0, 1: elements, differences and base extension are treated as two's-complement.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- din  dti.consumer  W_DATA+1  element stream; data = {eot (MSB), value}.
- dout  dti.producer  W_INCR+W_CNT+W_START+1  result; data = {err (MSB), incr, cnt, base} packed, base in LSBs.

Behaviour:
- Interface: one clock; reset is synchronous and active-high, ports clk and rst.
- Handshakes: din transfer on din.valid & din.ready; dout transfer on dout.valid & dout.ready. dout.data is stable while dout.valid & !dout.ready.
- FSM states:
  - FIRST: din.ready=1. Transfer latches base (value extended or truncated to W_START per SIGNED) and sets n=1. eot -> OUT with incr=0; else -> SECOND.
  - SECOND: din.ready=1. Transfer sets incr = value - prev, computed in W_DATA+1 bits and then sized to W_INCR (sign-extended if SIGNED). n++. eot -> OUT; else -> RUN.
  - RUN: din.ready=1. Each transfer compares value - prev against incr (full-precision compare). Mismatch sets sticky err. n++. eot -> OUT.
  - OUT: din.ready=0, dout.valid=1. On dout transfer -> FIRST; incr, n and err are cleared.
- prev register: updated with value on every din transfer.
- cnt field: prev (last value, sized to W_CNT) when CNT_STEPS=0; n when CNT_STEPS=1.
- n is W_CNT+1 bits wide. If n would exceed 2^W_CNT-1 with CNT_STEPS=1, err is set and n saturates.
- err is also set when:
  - incr does not fit W_INCR (overflow on sizing); or
  - base does not fit W_START; or
  - CNT_STEPS=0 and the last value does not fit W_CNT.
- Latency: dout.valid rises the cycle after the eot element's transfer. Minimum period per sequence is N+1 cycles for N elements. No overlap of output hold with input acceptance.
- Reset values: state=FIRST, dout.valid=0, din.ready=0 during the reset cycle and 1 after. err, incr, n, base and prev are all 0.
- Reset mid-sequence or while in OUT: partial sequence or pending result is discarded; no dout transfer occurs.
- Wrap-around: differences are computed at full precision, so 0xFFFF -> 0x0000 (unsigned) is incr mismatch, not +1.
- din.valid while in OUT: held off by din.ready=0. dout.ready may be constantly 1.

Optional Feature:
- Macro: RNG_DETECT_ERR_DROP_EN.
- Defined: results with err=1 are discarded. FSM goes OUT->FIRST internally in one cycle with dout.valid held 0. The err bit remains in dout.data and always reads 0.
- Undefined: err results are delivered like any other.

Test Plan:
- Unsigned, CNT_STEPS=0; stream 3,5,7,9(eot) -> one dout {err=0, incr=2, cnt=9, base=3}, valid one cycle after eot transfer.
- CNT_STEPS=1; single element 42(eot) -> {err=0, incr=0, cnt=1, base=42}; next stream 0,1(eot) -> {0,1,2,0}.
- Mismatch 10,20,31,40(eot) -> err=1, incr=10. With RNG_DETECT_ERR_DROP_EN: no dout transfer, next stream 1,2(eot) is delivered normally.
- SIGNED=1, CNT_STEPS=1; stream 5,2,-1,-4(eot) -> {err=0, incr=-3 (0xFFFD), cnt=4, base=5}.
- Backpressure: dout.ready=0 for 5 cycles after result -> dout.data stable, din.ready=0 throughout. On release, one transfer, then din.ready=1 the next cycle.
- Assert rst after 2 elements of 1,2,3,4(eot), then send 7,8(eot) -> only {0,1,8,7} is produced (CNT_STEPS=0).
